// File: rtl/dvs2_modem_pkg.sv
// Shared modem types and constellation helpers for the QPSK transmit path.
package dvs2_modem_pkg;

    localparam logic [7:0] MIDSCALE = 8'd128;

    typedef logic [1:0] dibit_t;
    typedef logic [1:0] phase_t;

    // Gray-coded dibit to phase step: 00->0, 01->1, 11->2, 10->3.
    function automatic phase_t gray_inc(input dibit_t d);
        case (d)
            2'b00:   return 2'd0;
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd3;
        endcase
    endfunction

    // Returns {i_neg, q_neg} for a constellation phase.
    function automatic logic [1:0] phase_to_sign(input phase_t p);
        case (p)
            2'd0:    return 2'b00;
            2'd1:    return 2'b10;
            2'd2:    return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

endpackage

// File: rtl/iq_byte_fifo.sv
// Byte FIFO with show-ahead read data and occupancy output; FIFO_DEPTH is a power of 2.
module iq_byte_fifo #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk_x16,
    input  logic                          i_rst_n,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    assign full    = (level == LW'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge i_clk_x16) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge i_clk_x16 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/qpsk_iq_mapper.sv
// Byte stream to zero-stuffed QPSK offset-binary I/Q, one sample per filter strobe.
// Define QPSK_IQ_MAPPER_DIFF_ENC_EN for differential Gray encoding instead of direct mapping.
module qpsk_iq_mapper
    import dvs2_modem_pkg::*;
#(
    parameter int SPS        = 4,
    parameter int AMPL       = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk_x16,
    input  logic                          i_rst_n,
    input  logic                          i_en,
    input  logic [7:0]                    i_data,
    input  logic                          i_data_valid,
    output logic                          o_data_ready,
    input  logic                          i_fir_ready,
    output logic [7:0]                    o_I,
    output logic [7:0]                    o_Q,
    output logic                          o_valid,
    output logic                          o_underflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);
    localparam int CNT_W = (SPS > 1) ? $clog2(SPS) : 1;

    logic             tick;
    logic             sym_slot;
    logic             have_sr;
    logic             pop;
    logic             slot_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rd_data;
    dibit_t           dibit;
    logic [1:0]       neg;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       sr;
    logic [1:0]       left;
    logic [7:0]       iq_i_p1;
    logic [7:0]       iq_q_p1;
    logic             vld_p1;
    logic             uf;

    function automatic logic [7:0] sample(input logic is_neg);
        logic signed [9:0] ampl_s;
        logic signed [9:0] sum;
        ampl_s = 10'(AMPL);
        sum    = $signed({2'b00, MIDSCALE}) + (is_neg ? -ampl_s : ampl_s);
        return sum[7:0];
    endfunction

    iq_byte_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk_x16 (i_clk_x16),
        .i_rst_n   (i_rst_n),
        .wr_en     (i_data_valid),
        .wr_data   (i_data),
        .rd_en     (pop),
        .rd_data   (fifo_rd_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (o_fifo_level)
    );

    assign o_data_ready = !fifo_full;
    assign tick         = i_fir_ready && i_en;
    assign sym_slot     = tick && (cnt == '0);
    assign have_sr      = (left != 2'd0);
    assign pop          = sym_slot && !have_sr && !fifo_empty;
    assign slot_data    = sym_slot && (have_sr || !fifo_empty);
    assign dibit        = have_sr ? sr[5:4] : fifo_rd_data[7:6];

`ifdef QPSK_IQ_MAPPER_DIFF_ENC_EN
    phase_t phase;
    phase_t phase_nxt;

    assign phase_nxt = phase + gray_inc(dibit);
    assign neg       = phase_to_sign(phase_nxt);

    always_ff @(posedge i_clk_x16 or negedge i_rst_n) begin
        if (!i_rst_n)
            phase <= '0;
        else if (slot_data)
            phase <= phase_nxt;
    end
`else
    assign neg = dibit;
`endif

    // Stage p1: registered sample, one cycle after the strobe
    always_ff @(posedge i_clk_x16 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt     <= '0;
            sr      <= '0;
            left    <= '0;
            uf      <= 1'b0;
            iq_i_p1 <= MIDSCALE;
            iq_q_p1 <= MIDSCALE;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= tick;
            if (tick) begin
                cnt <= (cnt == CNT_W'(SPS - 1)) ? '0 : cnt + 1'b1;
                if (slot_data) begin
                    iq_i_p1 <= sample(neg[1]);
                    iq_q_p1 <= sample(neg[0]);
                end else begin
                    iq_i_p1 <= MIDSCALE;
                    iq_q_p1 <= MIDSCALE;
                end
                if (sym_slot && have_sr) begin
                    sr   <= {sr[3:0], 2'b00};
                    left <= left - 1'b1;
                end else if (pop) begin
                    sr   <= fifo_rd_data[5:0];
                    left <= 2'd3;
                end else if (sym_slot) begin
                    uf <= 1'b1;
                end
            end
        end
    end

    assign o_I         = iq_i_p1;
    assign o_Q         = iq_q_p1;
    assign o_valid     = vld_p1;
    assign o_underflow = uf;

endmodule

// File: tb/tb_qpsk_iq_mapper.sv
// Directed bench for qpsk_iq_mapper with a queue-based reference model compared every cycle.
module tb_qpsk_iq_mapper;
    localparam int SPS  = 4;
    localparam int AMPL = 64;
    localparam int FD   = 4;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       fir_ready;
    logic [7:0] o_i;
    logic [7:0] o_q;
    logic       vld;
    logic       uf;
    logic [2:0] level;

    int n_total = 0;
    int n_pass  = 0;

    qpsk_iq_mapper #(.SPS(SPS), .AMPL(AMPL), .FIFO_DEPTH(FD)) dut (
        .i_clk_x16    (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_data       (data),
        .i_data_valid (data_valid),
        .o_data_ready (data_ready),
        .i_fir_ready  (fir_ready),
        .o_I          (o_i),
        .o_Q          (o_q),
        .o_valid      (vld),
        .o_underflow  (uf),
        .o_fifo_level (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bytes waiting, dibits of the byte in progress, symbol phase.
    logic [7:0] mq[$];
    logic [1:0] md[$];
    int         m_cnt;
    int         m_phase;
    int         inc;
    bit         m_uf;
    bit         acc;
    bit         neg_i;
    bit         neg_q;
    logic [7:0] byte_in;
    logic [7:0] b;
    logic [1:0] d;
    int         exp_i;
    int         exp_q;
    bit         exp_vld;

    function automatic int samp(input bit is_neg);
        return is_neg ? 128 - AMPL : 128 + AMPL;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            md.delete();
            m_cnt   = 0;
            m_phase = 0;
            m_uf    = 0;
            exp_i   = 128;
            exp_q   = 128;
            exp_vld = 0;
        end else begin
            acc     = data_valid && (mq.size() < FD);
            byte_in = data;
            exp_vld = 0;
            if (en && fir_ready) begin
                exp_vld = 1;
                exp_i   = 128;
                exp_q   = 128;
                if (m_cnt == 0) begin
                    if (md.size() == 0 && mq.size() > 0) begin
                        b = mq.pop_front();
                        for (int k = 3; k >= 0; k--)
                            md.push_back(b[2*k+1 -: 2]);
                    end
                    if (md.size() > 0) begin
                        d = md.pop_front();
`ifdef QPSK_IQ_MAPPER_DIFF_ENC_EN
                        inc     = (d == 2'b00) ? 0 : (d == 2'b01) ? 1 : (d == 2'b11) ? 2 : 3;
                        m_phase = (m_phase + inc) % 4;
                        neg_i   = (m_phase == 1) || (m_phase == 2);
                        neg_q   = (m_phase >= 2);
`else
                        neg_i = d[1];
                        neg_q = d[0];
`endif
                        exp_i = samp(neg_i);
                        exp_q = samp(neg_q);
                    end else begin
                        m_uf = 1;
                    end
                end
                m_cnt = (m_cnt + 1) % SPS;
            end
            if (acc)
                mq.push_back(byte_in);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            n_total++;
            if (vld === exp_vld && (!exp_vld || (o_i === 8'(exp_i) && o_q === 8'(exp_q))) &&
                o_i === 8'(exp_i) && o_q === 8'(exp_q) && uf === m_uf &&
                level === 3'(mq.size()) && data_ready === (mq.size() < FD))
                n_pass++;
            else
                $display("FAIL model t=%0t: got vld=%0d I=%0d Q=%0d uf=%0d lvl=%0d rdy=%0d, want vld=%0d I=%0d Q=%0d uf=%0d lvl=%0d rdy=%0d",
                         $time, vld, o_i, o_q, uf, level, data_ready,
                         exp_vld, exp_i, exp_q, m_uf, mq.size(), (mq.size() < FD));
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req)
            n_pass++;
        else
            $display("FAIL %s: got %0d, want %0d", name, act, req);
    endtask

    task automatic push(input logic [7:0] v);
        @(negedge clk);
        data_valid = 1'b1;
        data       = v;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic do_tick(output int ri, output int rq, output int rv);
        @(negedge clk);
        fir_ready = 1'b1;
        @(negedge clk);
        fir_ready = 1'b0;
        ri = o_i;
        rq = o_q;
        rv = vld;
        repeat (2) @(negedge clk);
    endtask

    task automatic run_byte_literal(input string name, input int ei[4], input int eq[4]);
        int ri, rq, rv;
        for (int s = 0; s < 16; s++) begin
            do_tick(ri, rq, rv);
            chk({name, "_vld"}, rv, 1);
            if (s % 4 == 0) begin
                chk({name, "_I"}, ri, ei[s/4]);
                chk({name, "_Q"}, rq, eq[s/4]);
            end else begin
                chk({name, "_I_mid"}, ri, 128);
                chk({name, "_Q_mid"}, rq, 128);
            end
        end
    endtask

    initial begin
        int ri, rq, rv;
        int ei[4];
        int eq[4];
        rst_n      = 1'b0;
        en         = 1'b1;
        data       = 8'h00;
        data_valid = 1'b0;
        fir_ready  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_I", o_i, 128);
        chk("rst_Q", o_q, 128);
        chk("rst_vld", vld, 0);
        chk("rst_uf", uf, 0);
        chk("rst_level", level, 0);
        chk("rst_ready", data_ready, 1);
        rst_n = 1'b1;

        // Byte 0x1B: dibits 00 01 10 11
        push(8'h1B);
`ifdef QPSK_IQ_MAPPER_DIFF_ENC_EN
        ei = '{192, 64, 192, 64};
        eq = '{192, 192, 192, 64};
`else
        ei = '{192, 192, 64, 64};
        eq = '{192, 64, 192, 64};
`endif
        run_byte_literal("b1B", ei, eq);
        chk("b1B_uf", uf, 0);

        // No data: underflow
        do_tick(ri, rq, rv);
        chk("uf_first", uf, 1);
        chk("uf_I", ri, 128);
        chk("uf_Q", rq, 128);
        for (int s = 1; s < 8; s++) begin
            do_tick(ri, rq, rv);
            chk("uf_I_mid", ri, 128);
        end
        chk("uf_sticky", uf, 1);

        // Fill FIFO past depth
        push(8'hE4);
        push(8'h00);
        push(8'hFF);
        push(8'h5A);
        chk("full_ready", data_ready, 0);
        chk("full_level", level, 4);
        push(8'h33);
        chk("full_level_5th", level, 4);
        do_tick(ri, rq, rv);
        chk("pop_level", level, 3);
        chk("pop_ready", data_ready, 1);
        for (int s = 1; s < 16; s++)
            do_tick(ri, rq, rv);

        // Enable low: strobes dropped, writes still accepted
        ri = o_i;
        rq = o_q;
        en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            fir_ready = 1'b1;
            @(negedge clk);
            fir_ready = 1'b0;
            chk("en0_vld", vld, 0);
        end
        chk("en0_I_hold", o_i, ri);
        chk("en0_Q_hold", o_q, rq);
        push(8'hA5);
        chk("en0_push_level", level, 4);
        en = 1'b1;

        // Async reset mid-byte
        do_tick(ri, rq, rv);
        chk("midbyte_vld", rv, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_I", o_i, 128);
        chk("arst_Q", o_q, 128);
        chk("arst_level", level, 0);
        chk("arst_ready", data_ready, 1);
        chk("arst_uf", uf, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(8'hC0);
        do_tick(ri, rq, rv);
        chk("post_rst_I", ri, 64);
        chk("post_rst_Q", rq, 64);
        chk("post_rst_uf", uf, 0);

        // Byte 0x5A from fresh reset: dibits 01 01 10 10
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push(8'h5A);
`ifdef QPSK_IQ_MAPPER_DIFF_ENC_EN
        ei = '{64, 64, 64, 192};
        eq = '{192, 64, 192, 192};
`else
        ei = '{192, 192, 64, 64};
        eq = '{64, 64, 192, 192};
`endif
        run_byte_literal("b5A", ei, eq);
        chk("b5A_uf", uf, 0);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/qpsk_iq_mapper.md
Name: qpsk_iq_mapper

Overview:
- Transmit-side source that feeds the IQ FIR pulse-shaping filter.
- Accepts a byte stream and splits each byte into four QPSK dibits, MSB dibit first.
- Maps each dibit to offset-binary 8-bit I/Q and zero-stuffs to SPS samples per symbol.
- Presents one I/Q pair per filter ready strobe, which arrives once every 16 clocks on i_clk_x16.

Parameters:
- SPS, 4, samples per symbol (1..16); sample 0 carries the symbol, samples 1..SPS-1 carry midscale.
- AMPL, 64, constellation magnitude about midscale (1..127).
- FIFO_DEPTH, 4, input byte FIFO depth (power of 2, 2..16).

Ports:
- i_clk_x16  in  1  system clock, 16x sample rate.
- i_rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  clock enable for the mapper datapath.
- i_data  in  8  input byte.
- i_data_valid  in  1  i_data qualifier.
- o_data_ready  out  1  FIFO not full; byte accepted when i_data_valid & o_data_ready.
- i_fir_ready  in  1  one-cycle strobe from the filter requesting the next sample.
- o_I  out  8  offset-binary I sample.
- o_Q  out  8  offset-binary Q sample.
- o_valid  out  1  one-cycle pulse, o_I/o_Q updated.
- o_underflow  out  1  sticky flag: a symbol slot found no data.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low. Ports are i_clk_x16 and i_rst_n.
- Reset values: o_I=o_Q=128, o_valid=0, o_underflow=0, FIFO empty, o_data_ready=1, sample counter=0, dibit shift register empty (0 dibits left), phase=0.
- FIFO writes are accepted regardless of i_en. o_data_ready=0 when full; a write while full cannot occur.
- Strobe: tick = i_fir_ready & i_en. Ticks with i_en=0 are dropped. With i_en=0, all state except the FIFO write path is frozen.
- Latency: o_I/o_Q/o_valid are registered and update exactly 1 cycle after the tick. The filter samples in that cycle. o_I/o_Q hold between updates.
- Sample counter: 0..SPS-1, increments on each tick and wraps to 0.
- On a tick with counter==0 (symbol slot):
  - If dibits remain in the shift register: shift out the top dibit.
  - Else if the FIFO is not empty: pop a byte in the same cycle and use its bits[7:6]; 3 dibits remain.
  - Else (underflow): output 128/128, set o_underflow, leave phase unchanged. Counter still advances.
- On a tick with counter!=0: output 128/128.
- Mapping, direct: I = b1 ? 128-AMPL : 128+AMPL; Q = b0 ? 128-AMPL : 128+AMPL (dibit = {b1,b0}).
- Same-cycle FIFO push and pop are allowed at any level; the level is unchanged.
- o_underflow clears only on reset.
- Reset mid-operation discards the FIFO contents and any partial byte.

Optional Feature:
- Macro: QPSK_IQ_MAPPER_DIFF_ENC_EN.
- With the macro defined: differential Gray encoding.
  - Phase increment: 00→0, 01→1, 11→2, 10→3.
  - phase <= phase+inc (mod 4) on each symbol slot that has data.
  - Output by phase: 0→(+,+), 1→(-,+), 2→(-,-), 3→(+,-), where + = 128+AMPL and - = 128-AMPL.
- Without the macro: direct mapping; no phase register is built.

Decomposition:
- Package dvs2_modem_pkg: MIDSCALE=8'd128; dibit type (2 bits); phase type (2 bits); Gray-increment and phase-to-sign functions.
- Sub-module iq_byte_fifo: synchronous FIFO with level output, parameterised by FIFO_DEPTH, async active-low reset.

Test Plan:
- Direct mapping, AMPL=64, SPS=4. Push byte 0x1B, then 16 ticks → symbol slots (192,192),(192,64),(64,192),(64,64). Each is followed by 3×(128,128). o_valid pulses 1 cycle after each tick. o_underflow=0.
- No data, 8 ticks → all outputs 128/128. o_underflow=1 after the first tick and stays 1.
- Push 5 bytes with FIFO_DEPTH=4 and no ticks → o_data_ready=0 after the 4th byte, o_fifo_level=4, 5th byte not accepted. First symbol tick → o_fifo_level=3, o_data_ready=1.
- Ticks with i_en=0 → no o_valid, counter and outputs unchanged. A FIFO push during i_en=0 still raises o_fifo_level.
- Assert i_rst_n=0 mid-byte, asynchronously between clock edges → o_I=o_Q=128 immediately, FIFO empty. After release, the next symbol slot uses the next newly pushed byte.
- QPSK_IQ_MAPPER_DIFF_ENC_EN, byte 0x5A (dibits 01 01 10 10): phases 1,2,1,0 → (64,192),(64,64),(64,192),(192,192).
